// File: rtl/counter_top.sv
// 4-digit decimal up/down counter on a multiplexed 7-segment display,
// driven by buttons or single-character UART commands, with UART echo.
//
// RX FSM:  RX_IDLE  | waiting for rx to fall
//          RX_START | half-bit wait, confirm start bit still low
//          RX_DATA  | sampling 8 data bits at bit centre, LSB first
//          RX_STOP  | sampling stop bit, byte accepted only if high
// TX FSM:  TX_IDLE  | line high, pops FIFO when it holds data
//          TX_START | driving start bit
//          TX_DATA  | driving 8 data bits, LSB first
//          TX_STOP  | driving stop bit
module counter_top #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int TICK_HZ    = 10,
    parameter int SCAN_HZ    = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       enable,
    input  logic       clear,
    input  logic       rx,
    output logic       tx,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);
    localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int TICK_CLKS = CLK_FREQ / TICK_HZ;
    localparam int SCAN_CLKS = CLK_FREQ / SCAN_HZ;
    localparam int BIT_W     = $clog2(BIT_CLKS + 1);
    localparam int TICK_W    = $clog2(TICK_CLKS + 1);
    localparam int SCAN_W    = $clog2(SCAN_CLKS + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);

    // ---------------- buttons: {clear, enable, mode}
    logic [2:0] btn_s1, btn_s2, btn_d, btn_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_d  <= '0;
        end else begin
            btn_s1 <= {clear, enable, mode};
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    assign btn_pulse = btn_s2 & ~btn_d;

    // ---------------- UART RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t        rx_state;
    logic             rx_s1, rx_sync;
    logic [BIT_W-1:0] rx_timer;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift, rx_data;
    logic             rx_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_timer <= BIT_W'(HALF_CLKS - 1);
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_timer == '0) begin
                        if (!rx_sync) begin
                            rx_timer <= BIT_W'(BIT_CLKS - 1);
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer == '0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_timer <= BIT_W'(BIT_CLKS - 1);
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer == '0) begin
                        if (rx_sync) begin
                            rx_done <= 1'b1;
                            rx_data <= rx_shift;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- command decode; OR-ing means a coincident button and command act once
    logic cmd_run, cmd_clear, cmd_mode;
    logic run_pulse, clear_pulse, mode_pulse;

    assign cmd_run     = rx_done && (rx_data == 8'h52 || rx_data == 8'h72);
    assign cmd_clear   = rx_done && (rx_data == 8'h43 || rx_data == 8'h63);
    assign cmd_mode    = rx_done && (rx_data == 8'h4D || rx_data == 8'h6D);
    assign run_pulse   = btn_pulse[1] | cmd_run;
    assign clear_pulse = btn_pulse[2] | cmd_clear;
    assign mode_pulse  = btn_pulse[0] | cmd_mode;

    // ---------------- counter datapath
    logic              run, dir;
    logic [13:0]       count;
    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            dir      <= 1'b0;
            count    <= '0;
            tick_cnt <= TICK_W'(TICK_CLKS - 1);
        end else begin
            if (run_pulse)  run <= ~run;
            if (mode_pulse) dir <= ~dir;
            if (clear_pulse) begin
                count    <= '0;
                tick_cnt <= TICK_W'(TICK_CLKS - 1);
            end else if (run) begin
                if (tick_cnt == '0) begin
                    tick_cnt <= TICK_W'(TICK_CLKS - 1);
                    if (!dir) count <= (count == 14'd9999) ? 14'd0 : count + 14'd1;
                    else      count <= (count == 14'd0) ? 14'd9999 : count - 14'd1;
                end else begin
                    tick_cnt <= tick_cnt - 1'b1;
                end
            end
        end
    end

    // ---------------- echo FIFO (drops on full, never overwrites)
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t tx_state;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = rx_done && !fifo_full;
    assign pop        = (tx_state == TX_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- UART TX
    logic [BIT_W-1:0] tx_timer;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                        tx       <= 1'b0;
                        tx_timer <= BIT_W'(BIT_CLKS - 1);
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_timer == '0) begin
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_timer <= BIT_W'(BIT_CLKS - 1);
                        tx_state <= TX_DATA;
                    end else begin
                        tx_timer <= tx_timer - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_timer == '0) begin
                        if (tx_bit == 3'd7) begin
                            // one cycle shorter: the pass through TX_IDLE completes the stop bit
                            tx       <= 1'b1;
                            tx_timer <= BIT_W'(BIT_CLKS - 2);
                            tx_state <= TX_STOP;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                            tx_timer <= BIT_W'(BIT_CLKS - 1);
                        end
                    end else begin
                        tx_timer <= tx_timer - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_timer == '0) tx_state <= TX_IDLE;
                    else                tx_timer <= tx_timer - 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- FND scanner
    function automatic logic [3:0] dec_digit(input logic [13:0] v);
        return 4'(v % 14'd10);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_sel;
    logic [3:0]        digit_val;

    always_comb begin
        digit_val = '0;
        case (digit_sel)
            2'd0: digit_val = dec_digit(count);
            2'd1: digit_val = dec_digit(count / 14'd10);
            2'd2: digit_val = dec_digit(count / 14'd100);
            2'd3: digit_val = dec_digit(count / 14'd1000);
            default: digit_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= SCAN_W'(SCAN_CLKS - 1);
            digit_sel <= '0;
            fnd_com   <= 4'b1110;
            fnd_data  <= 8'hC0;
        end else begin
            if (scan_cnt == '0) begin
                scan_cnt  <= SCAN_W'(SCAN_CLKS - 1);
                digit_sel <= digit_sel + 1'b1;
            end else begin
                scan_cnt <= scan_cnt - 1'b1;
            end
            fnd_com  <= ~(4'b0001 << digit_sel);
            fnd_data <= {1'b1, seg7(digit_val)};
        end
    end
endmodule

// File: tb/tb_counter_top.sv
// Directed bench for counter_top with scaled-down clock/baud/tick/scan rates.
`timescale 1ns/1ps
module tb_counter_top;
    localparam int BIT_CLKS = 10;
    localparam int BIT_NS   = BIT_CLKS * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0, enable = 1'b0, clear = 1'b0, rx = 1'b1;
    logic       tx;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] echo_q [$];

    counter_top #(
        .CLK_FREQ(2000), .BAUD_RATE(200), .TICK_HZ(100), .SCAN_HZ(500), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .clear(clear),
        .rx(rx), .tx(tx), .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_bit;
        #(BIT_NS);
        rx = 1'b1;
    endtask

    // which: 0 = mode, 1 = enable, 2 = clear; called on a falling clock edge
    task automatic pulse_btn(input int which);
        case (which)
            0: mode = 1'b1;
            1: enable = 1'b1;
            default: clear = 1'b1;
        endcase
        @(negedge clk);
        mode = 1'b0;
        enable = 1'b0;
        clear = 1'b0;
    endtask

    // tx frame decoder feeding echo_q
    initial begin
        logic [7:0] b;
        wait (rst === 1'b1);
        forever begin
            @(negedge tx);
            #(BIT_NS / 2);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    #(BIT_NS);
                    b[i] = tx;
                end
                #(BIT_NS);
                echo_q.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0] exp_echo [8];
        logic [7:0] exp_seg [4];
        logic [3:0] exp_com;
        logic       found;
        exp_echo = '{8'h52, 8'h43, 8'h4D, 8'h63, 8'h72, 8'h6D, 8'h61, 8'h52};
        exp_seg  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

        wait_cycles(3);
        check("reset_count", 32'(dut.count), 32'd0);
        check("reset_run", 32'(dut.run), 32'd0);
        check("reset_dir", 32'(dut.dir), 32'd0);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_fnd_com", 32'(fnd_com), 32'hE);
        check("reset_fnd_data", 32'(fnd_data), 32'hC0);
        rst = 1'b1;
        wait_cycles(5);

        send_byte(8'h52, 1'b1);
        check("R_run", 32'(dut.run), 32'd1);
        check("R_dir", 32'(dut.dir), 32'd0);
        wait_cycles(100);
        check("R_count_5", 32'(dut.count), 32'd5);
        wait_cycles(40);
        check("R_count_7", 32'(dut.count), 32'd7);

        send_byte(8'h43, 1'b1);
        check("C_count_0", 32'(dut.count), 32'd0);
        check("C_run", 32'(dut.run), 32'd1);
        wait_cycles(50);
        check("C_count_2", 32'(dut.count), 32'd2);

        send_byte(8'h4D, 1'b1);
        check("M_dir", 32'(dut.dir), 32'd1);
        send_byte(8'h63, 1'b1);
        check("c_count", 32'(dut.count), 32'd0);
        check("c_run", 32'(dut.run), 32'd1);
        send_byte(8'h72, 1'b1);
        check("r_run", 32'(dut.run), 32'd0);
        check("r_count", 32'(dut.count), 32'd9995);
        send_byte(8'h6D, 1'b1);
        check("m_dir", 32'(dut.dir), 32'd0);
        send_byte(8'h61, 1'b1);
        check("a_run", 32'(dut.run), 32'd0);
        check("a_dir", 32'(dut.dir), 32'd0);
        check("a_count", 32'(dut.count), 32'd9995);

        wait_cycles(300);
        check("echo_len_7", 32'(echo_q.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < echo_q.size()) check($sformatf("echo_%0d", i), 32'(echo_q[i]), 32'(exp_echo[i]));

        pulse_btn(1);
        wait_cycles(3);
        check("btn_enable_run", 32'(dut.run), 32'd1);
        pulse_btn(0);
        wait_cycles(3);
        check("btn_mode_dir", 32'(dut.dir), 32'd1);
        pulse_btn(2);
        wait_cycles(12);
        check("btn_clear_count", 32'(dut.count), 32'd0);
        check("btn_clear_run", 32'(dut.run), 32'd1);
        check("btn_clear_dir", 32'(dut.dir), 32'd1);
        wait_cycles(20);
        check("down_wrap_9999", 32'(dut.count), 32'd9999);
        pulse_btn(0);
        wait_cycles(19);
        check("up_wrap_0", 32'(dut.count), 32'd0);
        check("up_dir", 32'(dut.dir), 32'd0);
        wait_cycles(20);
        check("up_count_1", 32'(dut.count), 32'd1);

        // enable pulse timed to land in the same cycle as the 'R' decode
        fork
            send_byte(8'h52, 1'b1);
            begin
                wait_cycles(96);
                enable = 1'b1;
                @(negedge clk);
                enable = 1'b0;
            end
        join
        check("coincide_run", 32'(dut.run), 32'd0);
        check("coincide_dir", 32'(dut.dir), 32'd0);

        send_byte(8'h52, 1'b0);
        wait_cycles(20);
        check("badstop_run", 32'(dut.run), 32'd0);
        wait_cycles(300);
        check("echo_len_8", 32'(echo_q.size()), 32'd8);
        if (echo_q.size() > 7) check("echo_7", 32'(echo_q[7]), 32'(exp_echo[7]));

        pulse_btn(1);
        pulse_btn(2);
        wait_cycles(24690);
        check("count_1234", 32'(dut.count), 32'd1234);
        pulse_btn(1);
        wait_cycles(3);
        check("stop_run", 32'(dut.run), 32'd0);
        for (int d = 0; d < 4; d++) begin
            exp_com = 4'b1111;
            exp_com[d] = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (fnd_com === exp_com) found = 1'b1;
            end
            check($sformatf("fnd_found_%0d", d), 32'(found), 32'd1);
            check($sformatf("fnd_data_%0d", d), 32'(fnd_data), 32'(exp_seg[d]));
        end
        check("fnd_hold_count", 32'(dut.count), 32'd1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
